booth_mul_ctrl: RTL and testbench
=================================

// Module: booth_mul_ctrl
// PURPOSE
//  Sequencing FSM for the radix-16 Booth-encoded multiplier datapath.
//  - Accepts an operand-pair request through a valid/ready handshake.
//  - Strobes the multiplicand/multiplier register loads.
//  - Steps the datapath through WIDTH/4 Booth digits: shift, select partial product, accumulate.
//  - Presents the finished product through a valid/ready handshake.
//  - Sits between the multiplier's top-level I/O and the datapath registers and accumulator.
// PARAMETERS
//  WIDTH   32   operand width in bits; must be a multiple of 4 and >= 8 (elaboration $error otherwise)
//  NDIG    WIDTH/4   number of radix-16 Booth digits (localparam, not overridable)
//  CNT_W   max(1,$clog2(NDIG))   digit-counter width (localparam)
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  in_valid    in   1      operand pair present on datapath inputs
//  in_ready    out  1      controller can accept operands
//  out_valid   out  1      product in accumulator is final
//  out_ready   in   1      consumer takes product
//  abort       in   1      synchronous cancel of current operation
//  busy        out  1      operation in progress (state != IDLE)
//  load_op     out  1      load enable for multiplicand and multiplier registers
//  acc_clr     out  1      clear partial-product accumulator
//  acc_en      out  1      accumulate the selected partial product this cycle
//  shift_en    out  1      shift multiplier register right by 4 (next digit window)
//  digit_idx   out  CNT_W  index of Booth digit being processed, 0 = least significant
//  last_digit  out  1      digit_idx == NDIG-1 while acc_en high
// BEHAVIOUR
//  - Reset (async assert, sync deassert):
//    - state=IDLE, cnt=0.
//    - All outputs 0, except in_ready=1 once rst_n is high.
//  - States are IDLE, CALC and DONE. All outputs are decoded from registered state/cnt.
//  - IDLE:
//    - in_ready = !abort.
//    - Accept condition: in_valid && in_ready.
//    - On accept, in the same cycle: load_op=1, acc_clr=1; cnt<=0; next state CALC.
//    - in_valid while abort=1 is not accepted.
//  - CALC:
//    - in_ready=0; acc_en=1; digit_idx=cnt.
//    - shift_en=1 on every CALC cycle except the last digit.
//    - cnt<=cnt+1 each cycle.
//    - When cnt==NDIG-1: last_digit=1, next state DONE, cnt<=0.
//  - DONE:
//    - out_valid=1 and held stable until out_ready.
//    - On out_valid && out_ready: next state IDLE.
//    - No new operand is accepted in DONE, even with out_ready=1.
//  - Latency:
//    - Accept at cycle T; CALC occupies T+1..T+NDIG; out_valid first high at T+NDIG+1.
//    - WIDTH=32: 8 CALC cycles, out_valid at T+9.
//    - Minimum issue interval is NDIG+2 cycles.
//  - abort:
//    - In CALC or DONE: next state IDLE, cnt<=0, no out_valid pulse.
//    - Datapath outputs are 0 in the abort cycle.
//    - abort has priority over out_ready and over the last_digit transition.
//  - Mid-operation rst_n assertion returns to IDLE immediately. Outputs are 0 while reset is active.
//  - Counter never wraps in CALC; cnt is 0 in every non-CALC state.
//  - Output strobes are mutually consistent:
//    - load_op implies acc_clr.
//    - acc_en never coincides with load_op.
//    - out_valid never coincides with acc_en.
// TESTING
//  1. Reset, then in_valid=1 at T with WIDTH=32 -> load_op/acc_clr at T; acc_en T+1..T+8; digit_idx 0..7; out_valid at T+9.
//  2. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid held, busy=1, in_ready=0; out_ready=1 -> IDLE next cycle.
//  3. Back-to-back: in_valid held high continuously, out_ready=1 -> accepts every 10 cycles; exactly one out_valid per accept.
//  4. abort at digit_idx=3 -> IDLE next cycle, no out_valid; a new request is then accepted normally with digit_idx restarting at 0.
//  5. abort and out_ready both high in DONE, and abort on last_digit cycle -> IDLE, no handshake completed; in_valid+abort in IDLE -> not accepted.
//  6. rst_n low mid-CALC (digit_idx=5) -> all outputs 0 asynchronously; after release in_ready=1, cnt=0; WIDTH=8 run gives out_valid at T+3.

Source files
------------

// File: rtl/booth_mul_ctrl.sv
// Sequencing FSM for a radix-16 Booth multiplier datapath (load, NDIG digit steps, result handshake).
// Latency: accept at T, digit steps T+1..T+NDIG, out_valid from T+NDIG+1; issue interval NDIG+2.
// Backpressure: out_valid holds in DONE until out_ready; in_ready is low whenever not IDLE or aborting.
module booth_mul_ctrl #(
  parameter  int WIDTH = 32,
  localparam int NDIG  = WIDTH / 4,
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             abort,
  output logic             busy,
  output logic             load_op,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             shift_en,
  output logic [CNT_W-1:0] digit_idx,
  output logic             last_digit
);

  if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("booth_mul_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and digit counter registers; async reset parks the FSM in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: abort wins over both the final digit and the output handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !abort) state_d = S_CALC;
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (abort || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state/counter; strobes drop in an abort cycle and under reset.
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state_q != S_IDLE);
    load_op    = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    shift_en   = 1'b0;
    digit_idx  = '0;
    last_digit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = rst_n && !abort;
        load_op  = rst_n && !abort && in_valid;
        acc_clr  = rst_n && !abort && in_valid;
      end
      S_CALC: begin
        if (!abort) begin
          acc_en     = 1'b1;
          digit_idx  = cnt_q;
          shift_en   = (cnt_q != LAST_CNT);
          last_digit = (cnt_q == LAST_CNT);
        end
      end
      S_DONE: begin
        out_valid = !abort;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed bench for booth_mul_ctrl: a WIDTH=32 instance is checked throughout,
// plus a WIDTH=8 instance sharing the same inputs for the short-operand latency.
module tb_booth_mul_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready, abort;
  logic       in_ready, out_valid, busy, load_op, acc_clr, acc_en, shift_en, last_digit;
  logic [2:0] digit_idx;
  logic       in_ready8, out_valid8, busy8, load_op8, acc_clr8, acc_en8, shift_en8, last_digit8;
  logic [0:0] digit_idx8;
  logic [7:0] v32, v8;

  int n_pass  = 0;
  int n_total = 0;
  int acc_k[$];
  int n_out;

  always #5 clk = ~clk;

  booth_mul_ctrl #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .abort(abort), .busy(busy),
    .load_op(load_op), .acc_clr(acc_clr), .acc_en(acc_en), .shift_en(shift_en),
    .digit_idx(digit_idx), .last_digit(last_digit)
  );

  booth_mul_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_ready(out_ready), .abort(abort), .busy(busy8),
    .load_op(load_op8), .acc_clr(acc_clr8), .acc_en(acc_en8), .shift_en(shift_en8),
    .digit_idx(digit_idx8), .last_digit(last_digit8)
  );

  // Bit order: busy, in_ready, out_valid, load_op, acc_clr, acc_en, shift_en, last_digit
  assign v32 = {busy, in_ready, out_valid, load_op, acc_clr, acc_en, shift_en, last_digit};
  assign v8  = {busy8, in_ready8, out_valid8, load_op8, acc_clr8, acc_en8, shift_en8, last_digit8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    #2;
    chk("reset_outputs", {24'd0, v32}, 32'h00);
    chk("reset_digit", {29'd0, digit_idx}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post_reset_idle", {24'd0, v32}, 32'h40);

    // Single operation with 5 cycles of output backpressure
    cyc(); in_valid = 1'b1; settle();
    chk("accept_load", {24'd0, v32}, 32'h58);
    for (int i = 0; i < 8; i++) begin
      cyc(); in_valid = 1'b0; settle();
      chk($sformatf("calc_vec_%0d", i), {24'd0, v32},
          {24'd0, 8'h84 | ((i != 7) ? 8'h02 : 8'h00) | ((i == 7) ? 8'h01 : 8'h00)});
      chk($sformatf("calc_idx_%0d", i), {29'd0, digit_idx}, i);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(); settle();
      chk($sformatf("done_hold_%0d", i), {24'd0, v32}, 32'hA0);
    end
    out_ready = 1'b1; settle();
    chk("done_handshake", {24'd0, v32}, 32'hA0);
    cyc(); out_ready = 1'b0; settle();
    chk("idle_after_done", {24'd0, v32}, 32'h40);

    // Back-to-back stream with in_valid and out_ready held high
    in_valid = 1'b1; out_ready = 1'b1; n_out = 0;
    for (int k = 0; k < 30; k++) begin
      settle();
      if (load_op) acc_k.push_back(k);
      if (out_valid && out_ready) n_out++;
      if (k == 29) in_valid = 1'b0;
      cyc();
    end
    out_ready = 1'b0;
    chk("b2b_accepts", acc_k.size(), 32'd3);
    chk("b2b_outputs", n_out, 32'd3);
    chk("b2b_first", acc_k[0], 32'd0);
    chk("b2b_second", acc_k[1], 32'd10);
    chk("b2b_third", acc_k[2], 32'd20);
    settle();
    chk("b2b_idle", {24'd0, v32}, 32'h40);

    // Abort at digit 3, then a fresh request restarts from digit 0
    in_valid = 1'b1; settle();
    chk("abort_run_accept", {24'd0, v32}, 32'h58);
    cyc(); in_valid = 1'b0;
    repeat (3) cyc();
    chk("abort_at_idx3", {29'd0, digit_idx}, 32'd3);
    abort = 1'b1; settle();
    chk("abort_cycle_vec", {24'd0, v32}, 32'h80);
    chk("abort_cycle_idx", {29'd0, digit_idx}, 32'd0);
    cyc(); abort = 1'b0; settle();
    chk("abort_to_idle", {24'd0, v32}, 32'h40);
    in_valid = 1'b1; settle();
    chk("reaccept", {24'd0, v32}, 32'h58);
    cyc(); in_valid = 1'b0; settle();
    chk("restart_idx0", {29'd0, digit_idx}, 32'd0);
    chk("restart_vec", {24'd0, v32}, 32'h86);

    // Abort together with out_ready in DONE
    repeat (8) cyc();
    chk("reach_done", {24'd0, v32}, 32'hA0);
    abort = 1'b1; out_ready = 1'b1; settle();
    chk("abort_in_done", {24'd0, v32}, 32'h80);
    cyc(); abort = 1'b0; out_ready = 1'b0; settle();
    chk("abort_done_idle", {24'd0, v32}, 32'h40);

    // Abort on the last-digit cycle
    in_valid = 1'b1; cyc(); in_valid = 1'b0;
    repeat (7) cyc();
    chk("last_digit_pre", {24'd0, v32}, 32'h85);
    abort = 1'b1; settle();
    chk("abort_last_digit", {24'd0, v32}, 32'h80);
    cyc(); abort = 1'b0; settle();
    chk("abort_last_idle", {24'd0, v32}, 32'h40);

    // in_valid with abort in IDLE must not be accepted
    in_valid = 1'b1; abort = 1'b1; settle();
    chk("idle_abort_block", {24'd0, v32}, 32'h00);
    cyc(); in_valid = 1'b0; abort = 1'b0; settle();
    chk("idle_abort_stay", {24'd0, v32}, 32'h40);

    // Asynchronous reset in the middle of CALC
    in_valid = 1'b1; cyc(); in_valid = 1'b0;
    repeat (5) cyc();
    chk("pre_reset_idx5", {29'd0, digit_idx}, 32'd5);
    rst_n = 1'b0; #1;
    chk("async_reset_vec", {24'd0, v32}, 32'h00);
    chk("async_reset_idx", {29'd0, digit_idx}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("release_idle32", {24'd0, v32}, 32'h40);
    chk("release_idle8", {24'd0, v8}, 32'h40);
    chk("release_idx", {29'd0, digit_idx}, 32'd0);

    // WIDTH=8: two digits, out_valid at T+3
    cyc(); in_valid = 1'b1; settle();
    chk("w8_accept", {24'd0, v8}, 32'h58);
    cyc(); in_valid = 1'b0; settle();
    chk("w8_digit0", {24'd0, v8}, 32'h86);
    chk("w8_idx0", {31'd0, digit_idx8}, 32'd0);
    cyc(); settle();
    chk("w8_digit1", {24'd0, v8}, 32'h85);
    chk("w8_idx1", {31'd0, digit_idx8}, 32'd1);
    cyc(); settle();
    chk("w8_out_valid", {24'd0, v8}, 32'hA0);
    out_ready = 1'b1; cyc(); out_ready = 1'b0; settle();
    chk("w8_idle", {24'd0, v8}, 32'h40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
